apb_requester: RTL and testbench

- APB initiator: turns a simple valid/ready command port into APB SETUP/ACCESS transfers and returns read data or error on a valid/ready response port.
- It is the requester end of the APB bus driven by the existing APB slave agent and monitor, i.e. the role the bridge DUT plays.
- It serves as a standalone RTL master for slave-agent self-checks and as a reference model for the bridge's APB side.
- Single outstanding transfer; all APB outputs registered.

---
 rtl/apb_requester_pkg.sv | 32 +++
 rtl/apb_requester_if.sv | 42 ++++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_requester.sv | 97 +++++++++
 tb/tb_apb_requester.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: shared types and helpers for the APB requester slice.
//   state_e   - requester FSM states
//   rsp_t     - captured response (read data, error, timeout flag)
//   cnt_width - width of the ACCESS wait counter for a given timeout
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // rsp_t carries the widest supported data path. The requester's
    // DATA_WIDTH must not exceed RSP_DW.
    localparam int RSP_DW = 32;

    typedef struct packed {
        logic [RSP_DW-1:0] rdata;
        logic              err;
        logic              timeout;
    } rsp_t;

    // clog2(t+1), kept at least 1 bit so a disabled timeout (t=0) still
    // yields a legal vector.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    localparam int WAIT_CNT_W = cnt_width(16);

endpackage

// File: rtl/apb_requester_if.sv
// apb_requester_if: command, response and APB signals of the requester.
//   master - the requester (drives cmd_ready, rsp_*, Psel/Penable/Pwrite/Paddr/Pwdata)
//   slave  - the environment (command source, response sink, APB completer)
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  Psel;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic [DATA_WIDTH-1:0] Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               Prdata, Pready, Pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               Psel, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               Prdata, Pready, Pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               Psel, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles in which the slave holds Pready low.
//   Pclk, Preset - clock, asynchronous active-high reset
//   clr          - zero the count (held while not in ACCESS)
//   en           - count this cycle (ACCESS with Pready=0)
//   expired      - the current ACCESS cycle is the last one allowed
module apb_wait_timer
    import apb_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic Pclk,
    input  logic Preset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    // cnt holds the number of wait cycles already seen, so during the k-th
    // ACCESS cycle it reads k-1; saturating keeps it from wrapping.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != SAT)
            cnt <= cnt + CW'(1);
    end

    assign expired = (TIMEOUT_CYCLES > 0) && (cnt >= LAST);
endmodule

// File: rtl/apb_requester.sv
// apb_requester: APB initiator, one outstanding transfer.
//   Pclk, Preset - clock, asynchronous active-high reset
//   bus (master) - cmd_* valid/ready command in, rsp_* valid/ready response
//                  out, APB requester signals (all APB outputs registered)
// Flow: IDLE -> SETUP (1 cycle) -> ACCESS (until Pready or timeout) -> RESP
// (until rsp_ready) -> IDLE.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              Pclk,
    input logic              Preset,
    apb_requester_if.master  bus
);
    state_e                state;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    rsp_t                  rsp_q;
    logic                  expired;

    apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .Pclk    (Pclk),
        .Preset  (Preset),
        .clr     (state != ACCESS),
        .en      (state == ACCESS && !bus.Pready),
        .expired (expired)
    );

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rsp_q     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    pwrite_q <= bus.cmd_write;
                    paddr_q  <= bus.cmd_addr;
                    // Reads leave Pwdata untouched to avoid needless toggling.
                    if (bus.cmd_write)
                        pwdata_q <= bus.cmd_wdata;
                    psel_q <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // Completion is checked first so Pready on the timeout
                    // boundary cycle still yields a normal response.
                    if (bus.Pready) begin
                        rsp_q.rdata   <= pwrite_q ? '0 : RSP_DW'(bus.Prdata);
                        rsp_q.err     <= bus.Pslverr;
                        rsp_q.timeout <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= RESP;
                    end else if (expired) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so reset
    // clears rsp_valid (and raises cmd_ready) without a clock edge.
    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;
    assign bus.Psel        = psel_q;
    assign bus.Penable     = penable_q;
    assign bus.Pwrite      = pwrite_q;
    assign bus.Paddr       = paddr_q;
    assign bus.Pwdata      = pwdata_q;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed, table-driven check of apb_requester with
// TIMEOUT_CYCLES=16, plus hand sequences for backpressure and async reset.
module tb_apb_requester;
    import apb_requester_pkg::*;

    logic Pclk   = 1'b0;
    logic Preset = 1'b1;
    always #5 Pclk = ~Pclk;

    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    apb_requester #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Pclk   (Pclk),
        .Preset (Preset),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // waits = number of Pready=0 ACCESS cycles before completion;
    // waits >= 16 means the slave never answers.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        early_err;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic done;
        @(posedge Pclk); #1;
        chk("idle.cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        @(posedge Pclk); #1;
        // Scramble the command port: it must be ignored from here on.
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        bus.cmd_write = ~v.write;
        chk("setup.psel_en", {bus.Psel, bus.Penable}, 2'b10);
        chk("setup.paddr", bus.Paddr, v.addr);
        chk("setup.pwrite", bus.Pwrite, v.write);
        if (v.write) chk("setup.pwdata", bus.Pwdata, v.wdata);
        for (int i = 0; i < 16; i++) begin
            @(posedge Pclk); #1;
            chk("access.psel_en", {bus.Psel, bus.Penable}, 2'b11);
            chk("access.paddr", bus.Paddr, v.addr);
            done = (i == v.waits);
            bus.Pready  = done;
            bus.Prdata  = done ? v.prdata : (32'h0BAD_0000 + 32'(i));
            bus.Pslverr = done ? v.slverr : v.early_err;
            if (done) break;
        end
        @(posedge Pclk); #1;
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
        bus.Prdata  = 32'hFFFF_FFFF;
        chk("resp.valid", bus.rsp_valid, 1);
        chk("resp.psel_en", {bus.Psel, bus.Penable}, 2'b00);
        chk("resp.cmd_ready", bus.cmd_ready, 0);
        chk("resp.rdata", bus.rsp_rdata, v.exp_rdata);
        chk("resp.err", bus.rsp_err, v.exp_err);
        chk("resp.timeout", bus.rsp_timeout, v.exp_to);
        bus.rsp_ready = 1'b1;
        @(posedge Pclk); #1;
        bus.rsp_ready = 1'b0;
        chk("done.rsp_valid", bus.rsp_valid, 0);
        chk("done.cmd_ready", bus.cmd_ready, 1);
    endtask

    vec_t vecs[8];

    initial begin
        //           wr    addr          wdata         waits prdata        early slverr exp_rdata     err   to
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 0,  32'h7777_7777, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         3,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0024, 32'h0,         0,  32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0028, 32'h0,         2,  32'h0000_CAFE, 1'b1, 1'b0, 32'h0000_CAFE, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_002C, 32'h0,         99, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0030, 32'h0,         15, 32'h5555_AAAA, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0034, 32'h0F0F_0F0F, 1,  32'h9999_9999, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0038, 32'h1357_9BDF, 99, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b0;
        bus.Pslverr   = 1'b0;

        // Reset state
        #2;
        chk("rst.cmd_ready", bus.cmd_ready, 1);
        chk("rst.psel_en", {bus.Psel, bus.Penable}, 2'b00);
        chk("rst.rsp_valid", bus.rsp_valid, 0);
        chk("rst.paddr", bus.Paddr, 0);
        chk("rst.rsp", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 0);
        repeat (2) @(posedge Pclk);
        #1 Preset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response backpressure with a pending command
        @(posedge Pclk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40;
        @(posedge Pclk); #1;                        // SETUP
        bus.cmd_addr = 32'h44;
        @(posedge Pclk); #1;                        // ACCESS, zero wait
        bus.Pready = 1'b1; bus.Prdata = 32'h1111_2222;
        @(posedge Pclk); #1;                        // RESP
        bus.Pready = 1'b0; bus.Prdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("bp.cmd_ready", bus.cmd_ready, 0);
            chk("bp.rsp_valid", bus.rsp_valid, 1);
            chk("bp.rdata", bus.rsp_rdata, 32'h1111_2222);
            chk("bp.psel", bus.Psel, 0);
            @(posedge Pclk); #1;
        end
        bus.rsp_ready = 1'b1;
        chk("bp.hold_valid", bus.rsp_valid, 1);
        @(posedge Pclk); #1;                        // IDLE, accepts 0x44
        bus.rsp_ready = 1'b0;
        chk("bp.idle_valid", bus.rsp_valid, 0);
        chk("bp.idle_psel", bus.Psel, 0);
        @(posedge Pclk); #1;                        // SETUP, 2 cycles after handshake
        bus.cmd_valid = 1'b0;
        chk("bp.setup_psel_en", {bus.Psel, bus.Penable}, 2'b10);
        chk("bp.setup_paddr", bus.Paddr, 32'h44);
        @(posedge Pclk); #1;
        bus.Pready = 1'b1; bus.Prdata = 32'h3333_4444;
        @(posedge Pclk); #1;
        bus.Pready = 1'b0;
        chk("bp2.rdata", bus.rsp_rdata, 32'h3333_4444);
        bus.rsp_ready = 1'b1;
        @(posedge Pclk); #1;
        bus.rsp_ready = 1'b0;

        // Asynchronous reset mid-ACCESS
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h50;
        @(posedge Pclk); #1;                        // SETUP
        bus.cmd_valid = 1'b0;
        @(posedge Pclk); #1;                        // ACCESS, slave stalls
        chk("ar.access", {bus.Psel, bus.Penable}, 2'b11);
        #2 Preset = 1'b1;
        #1;
        chk("ar.psel_en", {bus.Psel, bus.Penable}, 2'b00);
        chk("ar.rsp_valid", bus.rsp_valid, 0);
        chk("ar.cmd_ready", bus.cmd_ready, 1);
        @(posedge Pclk); #1;
        Preset = 1'b0;
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
